// File: rtl/qspi_fetch_arbiter.sv
// Two-port arbiter in front of the QPI flash read engine: grants one requester, launches the engine, returns the word.
// Optional last-word buffer when QSPI_LWB_EN is defined.
module qspi_fetch_arbiter #(
  parameter int PRIO_MODE = 0,
  parameter int TIMEOUT   = 63,
  parameter int TW        = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic [23:0] p0_addr,
  output logic        p0_rdy,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic [23:0] p1_addr,
  output logic        p1_rdy,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  input  logic        lwb_inval,
  output logic [31:0] fi_addr,
  output logic        fi_addr_wr,
  output logic        fi_start,
  input  logic        fi_cs,
  input  logic [31:0] fi_data,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, START, WAIT_LOW, WAIT_HIGH, RESP} state_t;

  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          rr_last_q, rr_last_d;
  logic [21:0]   addr_q, addr_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic          err0_q, err0_d, err1_q, err1_d;

  logic          win;
  logic [21:0]   win_addr;
  logic          resp_load, resp_port, resp_err;
  logic [31:0]   resp_data;
  logic          unused_bits;

`ifdef QSPI_LWB_EN
  logic [21:0] tag_q, tag_d;
  logic [31:0] lwb_q, lwb_d;
  logic        vld_q, vld_d;
  assign unused_bits = ^{p0_addr[1:0], p1_addr[1:0]};
`else
  assign unused_bits = ^{p0_addr[1:0], p1_addr[1:0], lwb_inval};
`endif

  always_comb begin
    win = 1'b0;
    if (p1_req && !p0_req)
      win = 1'b1;
    else if (p0_req && p1_req && PRIO_MODE == 0)
      win = ~rr_last_q;
  end

  assign win_addr = win ? p1_addr[23:2] : p0_addr[23:2];

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_last_d = rr_last_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    resp_load = 1'b0;
    resp_port = owner_q;
    resp_err  = 1'b0;
    resp_data = fi_data;
`ifdef QSPI_LWB_EN
    tag_d = tag_q;
    lwb_d = lwb_q;
    vld_d = vld_q;
`endif
    case (state_q)
      IDLE: begin
        if (p0_req || p1_req) begin
          owner_d = win;
          addr_d  = win_addr;
          state_d = START;
`ifdef QSPI_LWB_EN
          if (vld_q && tag_q == win_addr) begin
            state_d   = RESP;
            resp_load = 1'b1;
            resp_port = win;
            resp_data = lwb_q;
          end
`endif
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT_LOW;
      end
      WAIT_LOW, WAIT_HIGH: begin
        cnt_d = cnt_q + TW'(1);
        if (state_q == WAIT_HIGH && fi_cs) begin
          resp_load = 1'b1;
          state_d   = RESP;
`ifdef QSPI_LWB_EN
          tag_d = addr_q;
          lwb_d = fi_data;
          vld_d = 1'b1;
`endif
        end else if (cnt_q == TO_LAST) begin
          // abort: zero data with error flag
          resp_load = 1'b1;
          resp_err  = 1'b1;
          resp_data = '0;
          state_d   = RESP;
`ifdef QSPI_LWB_EN
          vld_d = 1'b0;
`endif
        end else if (state_q == WAIT_LOW && !fi_cs) begin
          state_d = WAIT_HIGH;
        end
      end
      RESP: begin
        rr_last_d = owner_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef QSPI_LWB_EN
    if (lwb_inval)
      vld_d = 1'b0;
`endif
  end

  always_comb begin
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    err0_d   = err0_q;
    err1_d   = err1_q;
    if (resp_load) begin
      if (resp_port) begin
        rdata1_d = resp_data;
        err1_d   = resp_err;
      end else begin
        rdata0_d = resp_data;
        err0_d   = resp_err;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      rr_last_q <= 1'b1;
      addr_q    <= '0;
      cnt_q     <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
`ifdef QSPI_LWB_EN
      tag_q <= '0;
      lwb_q <= '0;
      vld_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
`ifdef QSPI_LWB_EN
      tag_q <= tag_d;
      lwb_q <= lwb_d;
      vld_q <= vld_d;
`endif
    end
  end

  assign fi_addr    = {8'h00, addr_q, 2'b00};
  assign fi_start   = (state_q == START);
  assign fi_addr_wr = (state_q == START);
  assign busy       = (state_q != IDLE);
  assign p0_rdy     = (state_q == RESP) && !owner_q;
  assign p1_rdy     = (state_q == RESP) && owner_q;
  assign p0_rdata   = rdata0_q;
  assign p1_rdata   = rdata1_q;
  assign p0_err     = err0_q;
  assign p1_err     = err1_q;

endmodule

// File: tb/tb_qspi_fetch_arbiter.sv
// Bench for qspi_fetch_arbiter: DUT 0 round-robin, DUT 1 fixed priority, each with its own engine model.
// Define QSPI_LWB_EN to also exercise the last-word buffer.
module tb_qspi_fetch_arbiter;

`ifdef QSPI_LWB_EN
  localparam bit LWB_ON = 1'b1;
`else
  localparam bit LWB_ON = 1'b0;
`endif
  localparam int TIMEOUT = 63;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic lwb_inval = 1'b0;
  logic [1:0] p0_req = '0, p1_req = '0;
  logic [1:0][23:0] p0_addr = '0, p1_addr = '0;
  logic [1:0] p0_rdy, p1_rdy, p0_err, p1_err, fi_addr_wr, fi_start, busy;
  logic [1:0][31:0] p0_rdata, p1_rdata, fi_addr;
  logic [1:0] fi_cs;
  logic [1:0][31:0] fi_data;

  int eng_delay[2] = '{10, 10};
  bit eng_hang[2] = '{0, 0};
  bit eng_ovr[2] = '{0, 0};
  logic [31:0] eng_word[2] = '{0, 0};
  int eng_cnt[2];
  int starts[2] = '{0, 0};
  int rdy0_cnt[2] = '{0, 0};
  int rdy1_cnt[2] = '{0, 0};
  int strobe_bad[2] = '{0, 0};
  logic [31:0] start_addr[2] = '{0, 0};

  int errors = 0;
  int checks = 0;

  int mdl_rr_last[2];
  bit mdl_vld[2];
  logic [21:0] mdl_tag[2];
  logic [31:0] mdl_data[2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    qspi_fetch_arbiter #(.PRIO_MODE(g), .TIMEOUT(TIMEOUT), .TW(8)) u_dut (
      .clk(clk), .reset(reset),
      .p0_req(p0_req[g]), .p0_addr(p0_addr[g]), .p0_rdy(p0_rdy[g]),
      .p0_rdata(p0_rdata[g]), .p0_err(p0_err[g]),
      .p1_req(p1_req[g]), .p1_addr(p1_addr[g]), .p1_rdy(p1_rdy[g]),
      .p1_rdata(p1_rdata[g]), .p1_err(p1_err[g]),
      .lwb_inval(lwb_inval),
      .fi_addr(fi_addr[g]), .fi_addr_wr(fi_addr_wr[g]), .fi_start(fi_start[g]),
      .fi_cs(fi_cs[g]), .fi_data(fi_data[g]), .busy(busy[g])
    );
  end

  function automatic logic [31:0] mem_word(input logic [23:0] a);
    return {a[23:2], 10'h000} ^ 32'h5A3C_96E1;
  endfunction

  // engine: CS low for eng_delay cycles after a start pulse
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      fi_cs <= 2'b11;
      fi_data <= '0;
      for (int g = 0; g < 2; g++) eng_cnt[g] <= 0;
    end else begin
      for (int g = 0; g < 2; g++) begin
        if (fi_start[g]) begin
          if (!eng_hang[g]) begin
            fi_cs[g] <= 1'b0;
            eng_cnt[g] <= eng_delay[g];
          end
          fi_data[g] <= eng_ovr[g] ? eng_word[g] : mem_word(fi_addr[g][23:0]);
        end else if (!fi_cs[g]) begin
          if (eng_cnt[g] <= 1) fi_cs[g] <= 1'b1;
          else eng_cnt[g] <= eng_cnt[g] - 1;
        end
      end
    end
  end

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (fi_start[g]) begin
        starts[g] <= starts[g] + 1;
        start_addr[g] <= fi_addr[g];
      end
      if (p0_rdy[g]) rdy0_cnt[g] <= rdy0_cnt[g] + 1;
      if (p1_rdy[g]) rdy1_cnt[g] <= rdy1_cnt[g] + 1;
      if (fi_start[g] !== fi_addr_wr[g] || (fi_start[g] && !busy[g]))
        strobe_bad[g] <= strobe_bad[g] + 1;
    end
  end

  function automatic int pick(input int d, input bit r0, input bit r1);
    if (r0 && !r1) return 0;
    if (r1 && !r0) return 1;
    if (d == 1) return 0;
    return (mdl_rr_last[d] == 0) ? 1 : 0;
  endfunction

  function automatic bit lwb_hit(input int d, input logic [23:0] a);
    return LWB_ON && mdl_vld[d] && (mdl_tag[d] == a[23:2]);
  endfunction

  task automatic model_done(input int d, input int owner, input logic [23:0] a,
                            input logic [31:0] w, input bit err);
    mdl_rr_last[d] = owner;
    if (err) mdl_vld[d] = 1'b0;
    else begin
      mdl_vld[d] = 1'b1;
      mdl_tag[d] = a[23:2];
      mdl_data[d] = w;
    end
  endtask

  task automatic reset_all();
    @(negedge clk);
    reset = 1'b0;
    p0_req = '0;
    p1_req = '0;
    lwb_inval = 1'b0;
    for (int g = 0; g < 2; g++) begin
      eng_hang[g] = 1'b0;
      eng_ovr[g] = 1'b0;
      eng_delay[g] = 10;
      mdl_rr_last[g] = 1;
      mdl_vld[g] = 1'b0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  // waits (bounded) for a rdy pulse on DUT d; cyc = posedges from the call
  task automatic serve(input int d, output int owner, output logic [31:0] data,
                       output logic err, output int cyc, output bit ok);
    ok = 1'b0; owner = -1; data = '0; err = 1'b0; cyc = 0;
    for (int i = 1; i <= 400 && !ok; i++) begin
      @(posedge clk); #1;
      if (p0_rdy[d] || p1_rdy[d]) begin
        ok = 1'b1;
        cyc = i;
        owner = p0_rdy[d] ? 0 : 1;
        data = p0_rdy[d] ? p0_rdata[d] : p1_rdata[d];
        err = p0_rdy[d] ? p0_err[d] : p1_err[d];
      end
    end
  endtask

  task automatic test_reset();
    reset_all();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({busy[d], fi_start[d], fi_addr_wr[d], p0_rdy[d], p1_rdy[d], p0_err[d], p1_err[d]} !== 7'b0) begin
        errors++;
        $display("FAIL reset_ctrl dut%0d: got %b want 0", d,
                 {busy[d], fi_start[d], fi_addr_wr[d], p0_rdy[d], p1_rdy[d], p0_err[d], p1_err[d]});
      end
      checks++;
      if ({fi_addr[d], p0_rdata[d], p1_rdata[d]} !== 96'h0) begin
        errors++;
        $display("FAIL reset_data dut%0d: got %h/%h/%h want 0", d, fi_addr[d], p0_rdata[d], p1_rdata[d]);
      end
    end
  endtask

  task automatic test_single_read();
    int owner, cyc, s0, r0, r1;
    logic [31:0] data;
    logic err;
    bit ok;
    reset_all();
    eng_ovr[0] = 1'b1;
    eng_word[0] = 32'hDEADBEEF;
    eng_delay[0] = 29;
    s0 = starts[0]; r0 = rdy0_cnt[0]; r1 = rdy1_cnt[0];
    p0_addr[0] = 24'h000104;
    p0_req[0] = 1'b1;
    serve(0, owner, data, err, cyc, ok);
    @(negedge clk);
    p0_req[0] = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (!ok || owner !== 0) begin
      errors++; $display("FAIL single_owner: got %0d want 0", owner);
    end
    checks++;
    if (data !== 32'hDEADBEEF || err !== 1'b0) begin
      errors++; $display("FAIL single_data: got %h err %b want deadbeef err 0", data, err);
    end
    checks++;
    if (starts[0] - s0 !== 1 || start_addr[0] !== 32'h00000104) begin
      errors++; $display("FAIL single_start: got %0d starts addr %h want 1 addr 00000104", starts[0] - s0, start_addr[0]);
    end
    checks++;
    if (rdy0_cnt[0] - r0 !== 1 || rdy1_cnt[0] - r1 !== 0) begin
      errors++; $display("FAIL single_rdy: got p0 %0d p1 %0d want 1 0", rdy0_cnt[0] - r0, rdy1_cnt[0] - r1);
    end
    model_done(0, 0, 24'h000104, 32'hDEADBEEF, 1'b0);
  endtask

  task automatic test_round_robin();
    int owner, cyc, s0, exp;
    logic [31:0] data;
    logic err;
    bit ok;
    reset_all();
    s0 = starts[0];
    p0_addr[0] = 24'h010000; p1_addr[0] = 24'h020000;
    p0_req[0] = 1'b1; p1_req[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp = pick(0, 1'b1, 1'b1);
      serve(0, owner, data, err, cyc, ok);
      checks++;
      if (!ok || owner !== exp) begin
        errors++; $display("FAIL rr_owner txn%0d: got %0d want %0d", i, owner, exp);
      end
      checks++;
      if (data !== mem_word(exp == 0 ? p0_addr[0] : p1_addr[0]) || err !== 1'b0) begin
        errors++; $display("FAIL rr_data txn%0d: got %h err %b", i, data, err);
      end
      model_done(0, exp, exp == 0 ? p0_addr[0] : p1_addr[0], data, 1'b0);
      @(negedge clk);
      if (exp == 0) p0_addr[0] = p0_addr[0] + 24'h4;
      else p1_addr[0] = p1_addr[0] + 24'h4;
      if (i == 3) begin
        p0_req[0] = 1'b0; p1_req[0] = 1'b0;
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (starts[0] - s0 !== 4) begin
      errors++; $display("FAIL rr_starts: got %0d want 4", starts[0] - s0);
    end
  endtask

  task automatic test_fixed_priority();
    int owner, cyc, exp;
    logic [31:0] data;
    logic err;
    bit ok;
    reset_all();
    p0_addr[1] = 24'h030010; p1_addr[1] = 24'h040020;
    p0_req[1] = 1'b1; p1_req[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp = pick(1, p0_req[1], p1_req[1]);
      serve(1, owner, data, err, cyc, ok);
      checks++;
      if (!ok || owner !== exp) begin
        errors++; $display("FAIL prio_owner txn%0d: got %0d want %0d", i, owner, exp);
      end
      checks++;
      if (data !== mem_word(exp == 0 ? p0_addr[1] : p1_addr[1])) begin
        errors++; $display("FAIL prio_data txn%0d: got %h", i, data);
      end
      model_done(1, exp, exp == 0 ? p0_addr[1] : p1_addr[1], data, 1'b0);
      @(negedge clk);
      if (exp == 0) p0_addr[1] = p0_addr[1] + 24'h4;
      if (i == 2) p0_req[1] = 1'b0;
      if (exp == 1) p1_req[1] = 1'b0;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout();
    int owner, cyc, s0;
    logic [31:0] data;
    logic err;
    bit ok;
    reset_all();
    eng_hang[0] = 1'b1;
    p0_addr[0] = 24'h000300;
    p0_req[0] = 1'b1;
    serve(0, owner, data, err, cyc, ok);
    checks++;
    if (!ok || owner !== 0 || err !== 1'b1 || data !== 32'h0) begin
      errors++; $display("FAIL timeout_resp: got owner %0d err %b data %h want 0 1 0", owner, err, data);
    end
    checks++;
    if (cyc !== TIMEOUT + 2) begin
      errors++; $display("FAIL timeout_cycles: got %0d want %0d", cyc, TIMEOUT + 2);
    end
    model_done(0, 0, 24'h000300, 32'h0, 1'b1);
    @(negedge clk);
    p0_req[0] = 1'b0;
    eng_hang[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (busy[0] !== 1'b0) begin
      errors++; $display("FAIL timeout_idle: got busy %b want 0", busy[0]);
    end
    s0 = starts[0];
    p1_addr[0] = 24'h000404;
    p1_req[0] = 1'b1;
    serve(0, owner, data, err, cyc, ok);
    @(negedge clk);
    p1_req[0] = 1'b0;
    checks++;
    if (!ok || owner !== 1 || err !== 1'b0 || data !== mem_word(24'h000404) || starts[0] - s0 !== 1) begin
      errors++; $display("FAIL timeout_recover: got owner %0d err %b data %h starts %0d", owner, err, data, starts[0] - s0);
    end
    model_done(0, 1, 24'h000404, data, 1'b0);
  endtask

  task automatic test_reset_mid();
    int owner, cyc, s0;
    logic [31:0] data;
    logic err;
    bit ok;
    bit seen;
    reset_all();
    eng_delay[0] = 30;
    p0_addr[0] = 24'h000500;
    p0_req[0] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk); #1;
      seen = fi_start[0];
    end
    repeat (6) @(negedge clk);
    checks++;
    if (!seen || busy[0] !== 1'b1 || fi_cs[0] !== 1'b0) begin
      errors++; $display("FAIL midrst_setup: got start %b busy %b cs %b want 1 1 0", seen, busy[0], fi_cs[0]);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++;
      if ({busy[0], p0_rdy[0], p1_rdy[0], fi_start[0]} !== 4'b0) begin
        errors++; $display("FAIL midrst_hold cyc%0d: got %b want 0000", i, {busy[0], p0_rdy[0], p1_rdy[0], fi_start[0]});
      end
      @(negedge clk);
    end
    p0_req[0] = 1'b0;
    reset = 1'b1;
    mdl_rr_last[0] = 1;
    mdl_vld[0] = 1'b0;
    eng_delay[0] = 5;
    @(negedge clk);
    s0 = starts[0];
    p0_addr[0] = 24'h000ABC;
    p0_req[0] = 1'b1;
    serve(0, owner, data, err, cyc, ok);
    @(negedge clk);
    p0_req[0] = 1'b0;
    checks++;
    if (!ok || owner !== 0 || data !== mem_word(24'h000ABC) || starts[0] - s0 !== 1) begin
      errors++; $display("FAIL midrst_after: got owner %0d data %h starts %0d", owner, data, starts[0] - s0);
    end
    model_done(0, 0, 24'h000ABC, data, 1'b0);
  endtask

  task automatic test_random(input int d);
    bit pend[2];
    logic [23:0] paddr[2];
    int owner, cyc, s0, exp, nexp;
    logic [31:0] data, wexp;
    logic err;
    bit ok, hit;
    reset_all();
    pend = '{0, 0};
    for (int r = 0; r < 12; r++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 1) == 1) begin
          pend[p] = 1'b1;
          paddr[p] = 24'($urandom);
        end
      end
      if (!pend[0] && !pend[1]) begin
        pend[0] = 1'b1;
        paddr[0] = 24'($urandom);
      end
      p0_req[d] = pend[0]; p0_addr[d] = paddr[0];
      p1_req[d] = pend[1]; p1_addr[d] = paddr[1];
      eng_delay[d] = $urandom_range(1, 40);
      exp = pick(d, pend[0], pend[1]);
      hit = lwb_hit(d, paddr[exp]);
      wexp = hit ? mdl_data[d] : mem_word(paddr[exp]);
      nexp = hit ? 0 : 1;
      s0 = starts[d];
      serve(d, owner, data, err, cyc, ok);
      checks++;
      if (!ok || owner !== exp || data !== wexp || err !== 1'b0 || starts[d] - s0 !== nexp) begin
        errors++;
        $display("FAIL rand dut%0d r%0d: got owner %0d data %h err %b starts %0d want %0d %h 0 %0d",
                 d, r, owner, data, err, starts[d] - s0, exp, wexp, nexp);
      end
      model_done(d, exp, paddr[exp], wexp, 1'b0);
      pend[exp] = 1'b0;
      if (exp == 0) p0_req[d] = 1'b0; else p1_req[d] = 1'b0;
    end
    @(negedge clk);
    p0_req[d] = 1'b0; p1_req[d] = 1'b0;
    repeat (50) @(negedge clk);
  endtask

`ifdef QSPI_LWB_EN
  task automatic test_lwb();
    int owner, cyc, s0;
    logic [31:0] data, first;
    logic err;
    bit ok;
    reset_all();
    s0 = starts[0];
    p0_addr[0] = 24'h000200;
    p0_req[0] = 1'b1;
    serve(0, owner, first, err, cyc, ok);
    @(negedge clk); p0_req[0] = 1'b0;
    @(negedge clk); p0_req[0] = 1'b1;
    serve(0, owner, data, err, cyc, ok);
    @(negedge clk); p0_req[0] = 1'b0;
    checks++;
    if (!ok || data !== first || first !== mem_word(24'h000200) || starts[0] - s0 !== 1) begin
      errors++; $display("FAIL lwb_hit: got data %h first %h starts %0d want %h 1", data, first, starts[0] - s0, mem_word(24'h000200));
    end
    checks++;
    if (cyc > 2) begin
      errors++; $display("FAIL lwb_latency: got %0d want <=2", cyc);
    end
    lwb_inval = 1'b1;
    @(negedge clk); lwb_inval = 1'b0;
    p0_req[0] = 1'b1;
    serve(0, owner, data, err, cyc, ok);
    @(negedge clk); p0_req[0] = 1'b0;
    checks++;
    if (!ok || data !== mem_word(24'h000200) || starts[0] - s0 !== 2) begin
      errors++; $display("FAIL lwb_inval: got data %h starts %0d want 2", data, starts[0] - s0);
    end
  endtask
`endif

  task automatic test_strobes();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (strobe_bad[d] !== 0) begin
        errors++; $display("FAIL strobes dut%0d: got %0d bad cycles want 0", d, strobe_bad[d]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_fixed_priority();
    test_timeout();
    test_reset_mid();
    test_random(0);
    test_random(1);
`ifdef QSPI_LWB_EN
    test_lwb();
`endif
    test_strobes();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/qspi_fetch_arbiter.md
Name: qspi_fetch_arbiter

Overview:
- Sequences the QPI flash read engine (EBh quad-read, 24-bit address, 32-bit result) on behalf of two requesters: port 0 (instruction fetch) and port 1 (data read).
- Arbitrates between the ports, latches the winning address, and issues a one-cycle start pulse to the engine.
- Tracks the engine's chip-select to detect transaction completion, then returns the word with a one-cycle ready pulse.
- Sits between the AHB flash-window slave logic and the flash engine.

Parameters:
- PRIO_MODE, 0: 0 = round-robin between ports; 1 = fixed priority, port 0 wins.
- TIMEOUT, 63: maximum cycles in WAIT before the transaction is aborted with an error; legal range 31..255.
- TW, 8: width of the timeout counter.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low.
- p0_req  in  1  port 0 read request; held high until p0_rdy.
- p0_addr  in  24  port 0 byte address; stable while p0_req is high.
- p0_rdy  out  1  one-cycle completion pulse for port 0.
- p0_rdata  out  32  port 0 read data; valid when p0_rdy=1.
- p0_err  out  1  timeout flag; valid when p0_rdy=1.
- p1_req, p1_addr, p1_rdy, p1_rdata, p1_err  same as port 0, for port 1.
- lwb_inval  in  1  invalidate the last-word buffer (optional feature only; ignored otherwise).
- fi_addr  out  32  engine address: {8'h00, addr[23:2], 2'b00}.
- fi_addr_wr  out  1  engine address-write strobe; same timing as fi_start.
- fi_start  out  1  engine start pulse.
- fi_cs  in  1  engine chip-select, active-low; high when the engine is idle.
- fi_data  in  32  engine result word.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: state=IDLE; fi_start, fi_addr_wr, p0_rdy, p1_rdy, p0_err, p1_err = 0; fi_addr = 0; p0_rdata, p1_rdata = 0; rr_last = 1 (port 0 wins the first tie); timeout counter = 0.
- FSM states: IDLE, START, WAIT_LOW, WAIT_HIGH, RESP.
- IDLE:
  - Stays in IDLE if neither request is high.
  - Otherwise picks the owner: a single requester wins directly. On a tie, PRIO_MODE=1 picks port 0; PRIO_MODE=0 picks the port that is not rr_last.
  - Latches owner and fi_addr; goes to START.
- START:
  - fi_start = fi_addr_wr = 1 for exactly this cycle.
  - Clears the counter; goes to WAIT_LOW.
- WAIT_LOW:
  - Waits for fi_cs=0; then goes to WAIT_HIGH.
- WAIT_HIGH:
  - Waits for fi_cs=1, which marks completion and fi_data as valid.
  - Captures fi_data into the owner's rdata register, err=0; goes to RESP.
- Timeout:
  - The counter increments each cycle in WAIT_LOW and WAIT_HIGH.
  - When the counter reaches TIMEOUT: rdata=32'h0, err=1, go to RESP.
- RESP:
  - The owner's rdy = 1 for one cycle. Non-owner outputs stay 0.
  - rr_last = owner; goes to IDLE.
- Latency: a request arriving in IDLE sees rdy 3 + (engine cycles) + 1 cycles later. The back-to-back dead time is 1 cycle (IDLE).
- Requests are sampled only in IDLE. A request rising mid-transaction waits.
- The owner dropping req mid-transaction is illegal; the transaction still completes and rdy still pulses.
- rdata holds its value until the next completion for that port.
- Reset asserted mid-transaction forces IDLE immediately. fi_start is never re-issued until a new arbitration.
- fi_start and fi_addr_wr are never high outside START.

Optional Feature:
- Macro QSPI_LWB_EN adds a last-word buffer: a 22-bit tag (addr[23:2]), a 32-bit data register, and a valid bit.
  - In IDLE, if the winner's addr[23:2] equals the tag and valid=1, the FSM goes straight to RESP with the buffered data. No fi_start is issued; rdy arrives 2 cycles after the request.
  - Every non-error completion loads the tag and data and sets valid. A timeout clears valid.
  - Reset clears valid. lwb_inval=1 clears valid on the next posedge and takes priority over a same-cycle load.
- Without the macro, every request goes to the engine and lwb_inval is unused.

Test Plan:
- Single p0 read, addr=24'h000104, engine model returns 32'hDEADBEEF after a 29-cycle CS-low window -> one fi_start with fi_addr=32'h00000104; p0_rdy pulses once; p0_rdata=32'hDEADBEEF; p0_err=0; p1_rdy stays 0.
- PRIO_MODE=0, p0 and p1 held high together for 4 transactions -> grant order p0, p1, p0, p1; exactly 4 fi_start pulses.
- PRIO_MODE=1, both ports held high -> p0 is served every transaction; p1 is served only after p0_req drops.
- Engine model never lowers fi_cs after start -> after TIMEOUT=63 WAIT cycles, owner rdy=1, err=1, rdata=0; the FSM returns to IDLE and the next request works normally.
- Reset pulsed during WAIT_HIGH -> busy=0, all rdy=0, fi_start=0 while reset is low; a new request afterward gets a fresh fi_start.
- With QSPI_LWB_EN: read 24'h000200 twice -> only one fi_start, second rdy 2 cycles after its request with the same data. After a lwb_inval pulse, a third read issues a new fi_start.
